// File: rtl/mac_job_scheduler.sv
// Job sequencer for a single MAC unit: runs T back-to-back dot products of length K,
// streaming gapless operands into the unit and returning each tile result on a valid/ready port.
module mac_job_scheduler #(
  parameter int MULER_WIDTH  = 8,
  parameter int NUM_WIDTH    = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int MULER_DELAY  = 1,
  parameter int TILE_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [NUM_WIDTH-1:0]      cmd_len,
  input  logic [TILE_WIDTH-1:0]     cmd_tiles,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [2*MULER_WIDTH-1:0]  op_data,
  output logic                      mac_num_valid,
  output logic [NUM_WIDTH-1:0]      mac_num,
  output logic [2*MULER_WIDTH-1:0]  mac_data,
  input  logic                      mac_data_ready,
  input  logic [OUTPUT_WIDTH-1:0]   mac_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [OUTPUT_WIDTH-1:0]   res_data,
  output logic                      res_last,
  output logic                      busy,
  output logic                      err
);

  localparam int WD_W = $clog2((1 << NUM_WIDTH) + MULER_DELAY + 6);

  typedef enum logic [2:0] {
    IDLE, LOAD, STREAM, DRAIN, CAPTURE, OUTPUT
  } state_t;

  state_t                  state, state_nxt;
  logic [NUM_WIDTH-1:0]    k_q;
  logic [TILE_WIDTH-1:0]   tiles_left;
  logic [NUM_WIDTH-1:0]    beat_cnt;
  logic [WD_W-1:0]         wd_cnt;
  logic [WD_W-1:0]         wd_limit;
  logic                    cmd_bad;
  logic                    last_tile;
  logic                    wd_expired;

  assign cmd_bad    = (cmd_len == '0) || (cmd_tiles == '0);
  assign last_tile  = (tiles_left == TILE_WIDTH'(1));
  // Watchdog counts cycles since the LOAD pulse; the unit must answer within K + delay + margin.
  assign wd_limit   = WD_W'(k_q) + WD_W'(MULER_DELAY + 4);
  assign wd_expired = (wd_cnt >= wd_limit);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    op_ready      = 1'b0;
    mac_num_valid = 1'b0;
    mac_num       = '0;
    mac_data      = '0;
    res_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_bad) state_nxt = LOAD;
      end
      LOAD: begin
        if (op_valid) begin
          mac_num_valid = 1'b1;
          mac_num       = k_q - 1'b1;
          state_nxt     = STREAM;
        end
      end
      STREAM: begin
        // The MAC counter is cycle-based, so a bubble still occupies a beat and injects zero.
        op_ready = 1'b1;
        if (op_valid) mac_data = op_data;
        if (beat_cnt == NUM_WIDTH'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (mac_data_ready)  state_nxt = CAPTURE;
        else if (wd_expired) state_nxt = IDLE;
      end
      CAPTURE: state_nxt = OUTPUT;
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = last_tile ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      tiles_left <= '0;
      beat_cnt   <= '0;
      wd_cnt     <= '0;
      res_data   <= '0;
      res_last   <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            k_q        <= cmd_len;
            tiles_left <= cmd_tiles;
            err        <= cmd_bad;
          end
        end
        LOAD: begin
          if (op_valid) begin
            beat_cnt <= k_q;
            wd_cnt   <= WD_W'(1);
          end
        end
        STREAM: begin
          beat_cnt <= beat_cnt - 1'b1;
          wd_cnt   <= wd_cnt + 1'b1;
          if (!op_valid) err <= 1'b1;
        end
        DRAIN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (!mac_data_ready && wd_expired) err <= 1'b1;
        end
        CAPTURE: begin
          // result_r in the unit settles one cycle after data_ready, i.e. now.
          res_data <= mac_result;
          res_last <= last_tile;
        end
        OUTPUT: begin
          if (res_ready && !last_tile) tiles_left <= tiles_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler with a behavioural MAC unit model
// (load pulse clears, K cycle-based beats, data_ready one cycle later, result_r one cycle after that).
module tb_mac_job_scheduler;

  localparam int MW = 8;
  localparam int NW = 8;
  localparam int OW = 32;
  localparam int MD = 1;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [NW-1:0]   cmd_len;
  logic [TW-1:0]   cmd_tiles;
  logic            op_valid;
  logic            op_ready;
  logic [2*MW-1:0] op_data;
  logic            mac_num_valid;
  logic [NW-1:0]   mac_num;
  logic [2*MW-1:0] mac_data;
  logic            mac_data_ready;
  logic [OW-1:0]   mac_result;
  logic            res_valid;
  logic            res_ready;
  logic [OW-1:0]   res_data;
  logic            res_last;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  mac_job_scheduler #(
    .MULER_WIDTH(MW), .NUM_WIDTH(NW), .OUTPUT_WIDTH(OW), .MULER_DELAY(MD), .TILE_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_tiles(cmd_tiles),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .mac_num_valid(mac_num_valid), .mac_num(mac_num), .mac_data(mac_data),
    .mac_data_ready(mac_data_ready), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .err(err)
  );

  // Behavioural MAC unit
  logic [OW-1:0] acc;
  int            beats_left;
  logic          drp;
  logic          hang;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      beats_left <= 0;
      drp        <= 1'b0;
      mac_result <= '0;
    end else begin
      drp <= 1'b0;
      if (mac_num_valid) begin
        acc        <= '0;
        beats_left <= int'(mac_num) + 1;
      end else if (beats_left > 0) begin
        acc        <= acc + OW'(mac_data[MW-1:0]) * OW'(mac_data[2*MW-1:MW]);
        beats_left <= beats_left - 1;
        drp        <= (beats_left == 1);
      end
      if (drp) mac_result <= acc;
    end
  end
  assign mac_data_ready = drp && !hang;

  // Event monitor, sampled on the falling edge
  int            cyc = 0, n_load = 0, n_stream = 0, n_bubble = 0, bubble_bad = 0;
  int            mdata_bad = 0, load_data_bad = 0, n_res = 0, stall_cyc = 0, instab = 0;
  int            load_cyc = 0, idle_cyc = 0;
  logic [NW-1:0] last_num = '0;
  logic [OW-1:0] res_log [0:7];
  logic          rlast_log [0:7];
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_busy = 1'b0;
  logic [OW-1:0] prev_d = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mac_num_valid) begin
      n_load   <= n_load + 1;
      last_num <= mac_num;
      load_cyc <= cyc;
      if (mac_data !== '0) load_data_bad <= load_data_bad + 1;
    end
    if (op_ready) begin
      n_stream <= n_stream + 1;
      if (op_valid) begin
        if (mac_data !== op_data) mdata_bad <= mdata_bad + 1;
      end else begin
        n_bubble <= n_bubble + 1;
        if (mac_data !== '0) bubble_bad <= bubble_bad + 1;
      end
    end
    if (res_valid && res_ready) begin
      res_log[n_res % 8]   <= res_data;
      rlast_log[n_res % 8] <= res_last;
      n_res                <= n_res + 1;
    end
    if (res_valid && !res_ready) stall_cyc <= stall_cyc + 1;
    if (prev_v && !prev_r && (!res_valid || res_data !== prev_d || res_last !== prev_l))
      instab <= instab + 1;
    if (prev_busy && !busy) idle_cyc <= cyc;
    prev_v    <= res_valid;
    prev_r    <= res_ready;
    prev_d    <= res_data;
    prev_l    <= res_last;
    prev_busy <= busy;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2*MW-1:0] ops [0:15];

  task automatic send_cmd(input int k, input int t);
    int w;
    tick();
    cmd_valid = 1'b1;
    cmd_len   = NW'(k);
    cmd_tiles = TW'(t);
    w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    check("cmd_accept_wait", 64'(w < 50), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Drives operands and result back-pressure until the scheduler returns to IDLE.
  task automatic run_job(input int n_ops, input int bubble, input int stall_res,
                         input int stall_n, input int budget);
    int idx, scyc, nres, stall_left;
    bit done;
    idx = 0; scyc = 0; nres = 0; stall_left = stall_n; done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      if (op_ready) scyc++;
      op_valid = (idx < n_ops) && !(op_ready && scyc == bubble);
      op_data  = (idx < n_ops) ? ops[idx] : '0;
      if (res_valid && nres == stall_res && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = 1'b1;
      end
      @(negedge clk);
      if (op_valid && op_ready) idx++;
      if (res_valid && res_ready) nres++;
      if (!busy) done = 1;
      else tick();
    end
    check("job_completes", 64'(done), 64'd1);
    op_valid  = 1'b0;
    res_ready = 1'b1;
  endtask

  int b_load, b_stream, b_bubble, b_res, b_stall, b_instab;

  task automatic snap();
    b_load = n_load; b_stream = n_stream; b_bubble = n_bubble;
    b_res = n_res; b_stall = stall_cyc; b_instab = instab;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_tiles = '0;
    op_valid = 1'b0; op_data = '0; res_ready = 1'b1; hang = 1'b0;
    repeat (2) tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_op_ready", 64'(op_ready), 64'd0);
    check("rst_mac_num_valid", 64'(mac_num_valid), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    // Single tile, K=4: 1*2+3*4+5*6+7*8 = 100
    ops[0] = {8'd2, 8'd1}; ops[1] = {8'd4, 8'd3}; ops[2] = {8'd6, 8'd5}; ops[3] = {8'd8, 8'd7};
    snap();
    send_cmd(4, 1);
    check("t1_busy_after_cmd", 64'(busy), 64'd1);
    run_job(4, 0, -1, 0, 100);
    tick();
    check("t1_load_pulses", 64'(n_load - b_load), 64'd1);
    check("t1_mac_num", 64'(last_num), 64'd3);
    check("t1_stream_beats", 64'(n_stream - b_stream), 64'd4);
    check("t1_results", 64'(n_res - b_res), 64'd1);
    check("t1_res_data", 64'(res_log[b_res % 8]), 64'd100);
    check("t1_res_last", 64'(rlast_log[b_res % 8]), 64'd1);
    check("t1_err", 64'(err), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Three tiles of K=3 with (2,3): 18 each; tile 2 result stalled 5 cycles
    for (int i = 0; i < 9; i++) ops[i] = {8'd3, 8'd2};
    snap();
    send_cmd(3, 3);
    run_job(9, 0, 1, 5, 300);
    tick();
    check("t2_results", 64'(n_res - b_res), 64'd3);
    check("t2_res0", 64'(res_log[b_res % 8]), 64'd18);
    check("t2_res1", 64'(res_log[(b_res + 1) % 8]), 64'd18);
    check("t2_res2", 64'(res_log[(b_res + 2) % 8]), 64'd18);
    check("t2_last0", 64'(rlast_log[b_res % 8]), 64'd0);
    check("t2_last1", 64'(rlast_log[(b_res + 1) % 8]), 64'd0);
    check("t2_last2", 64'(rlast_log[(b_res + 2) % 8]), 64'd1);
    check("t2_load_pulses", 64'(n_load - b_load), 64'd3);
    check("t2_stream_beats", 64'(n_stream - b_stream), 64'd9);
    check("t2_stall_cycles", 64'(stall_cyc - b_stall), 64'd5);
    check("t2_stall_stable", 64'(instab - b_instab), 64'd0);
    check("t2_err", 64'(err), 64'd0);

    // K=4 with a bubble on the 3rd beat: 1+1+0+1 = 3, err set
    for (int i = 0; i < 3; i++) ops[i] = {8'd1, 8'd1};
    snap();
    send_cmd(4, 1);
    run_job(3, 3, -1, 0, 100);
    tick();
    check("t3_stream_beats", 64'(n_stream - b_stream), 64'd4);
    check("t3_bubbles", 64'(n_bubble - b_bubble), 64'd1);
    check("t3_bubble_zero", 64'(bubble_bad), 64'd0);
    check("t3_results", 64'(n_res - b_res), 64'd1);
    check("t3_res_data", 64'(res_log[b_res % 8]), 64'd3);
    check("t3_err", 64'(err), 64'd1);

    // Zero-length command
    snap();
    send_cmd(0, 3);
    repeat (3) tick();
    check("t4a_err", 64'(err), 64'd1);
    check("t4a_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t4a_busy", 64'(busy), 64'd0);
    check("t4a_no_load", 64'(n_load - b_load), 64'd0);
    check("t4a_no_result", 64'(n_res - b_res), 64'd0);

    // Watchdog: K=2, MAC never answers; IDLE reached K+MD+4+1 cycles after the pulse
    hang = 1'b1;
    ops[0] = {8'd1, 8'd1}; ops[1] = {8'd1, 8'd1};
    snap();
    send_cmd(2, 1);
    check("t5_err_cleared", 64'(err), 64'd0);
    run_job(2, 0, -1, 0, 100);
    tick();
    check("t5_err", 64'(err), 64'd1);
    check("t5_no_result", 64'(n_res - b_res), 64'd0);
    check("t5_timeout_cycles", 64'(idle_cyc - load_cyc), 64'd8);
    check("t5_busy", 64'(busy), 64'd0);
    hang = 1'b0;

    // Async reset in STREAM of a K=8 job (after a bubble has set err)
    snap();
    send_cmd(8, 1);
    op_valid = 1'b1; op_data = {8'd1, 8'd1};
    tick();
    op_valid = 1'b0;
    tick();
    check("t6_in_stream", 64'(op_ready), 64'd1);
    check("t6_err_before_rst", 64'(err), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_op_ready", 64'(op_ready), 64'd0);
    check("t6_rst_mac_data", 64'(mac_data), 64'd0);
    check("t6_rst_res_data", 64'(res_data), 64'd0);
    check("t6_rst_err", 64'(err), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    check("t6_no_result", 64'(n_res - b_res), 64'd0);
    ops[0] = {8'd5, 8'd5};
    snap();
    send_cmd(1, 1);
    run_job(1, 0, -1, 0, 50);
    tick();
    check("t6_results", 64'(n_res - b_res), 64'd1);
    check("t6_res_data", 64'(res_log[b_res % 8]), 64'd25);
    check("t6_res_last", 64'(rlast_log[b_res % 8]), 64'd1);
    check("t6_err", 64'(err), 64'd0);

    // Zero-tile command after a clean job
    snap();
    send_cmd(2, 0);
    repeat (3) tick();
    check("t4b_err", 64'(err), 64'd1);
    check("t4b_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t4b_no_load", 64'(n_load - b_load), 64'd0);
    check("t4b_no_result", 64'(n_res - b_res), 64'd0);

    check("beat_data_passthrough", 64'(mdata_bad), 64'd0);
    check("load_pulse_data_zero", 64'(load_data_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mac_job_scheduler.md
Name: mac_job_scheduler

Overview:
- Sequences one mac_unit_no_output_broadcast-style MAC unit through a job of back-to-back dot products (tiles).
- Accepts a job command, then per tile: loads the length into the unit, streams gapless operand pairs from an upstream operand source, waits for the unit's data_ready, captures the result and hands it downstream on a valid/ready port.
- Sits between the operand fetch buffer and the result writeback path of the matrix multiplier.

Parameters:
- MULER_WIDTH, 8, width of each operand.
- NUM_WIDTH, 8, width of the dot-product length / MAC counter.
- OUTPUT_WIDTH, 32, width of the MAC result.
- MULER_DELAY, 1, MAC core pipeline delay; used only for the watchdog bound.
- TILE_WIDTH, 8, width of the tile count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  scheduler can accept a job
- cmd_len  in  NUM_WIDTH  dot-product length K per tile; legal range 1..2^NUM_WIDTH-1
- cmd_tiles  in  TILE_WIDTH  number of tiles T; legal range 1..2^TILE_WIDTH-1
- op_valid  in  1  operand pair valid
- op_ready  out  1  scheduler consumes operand pair
- op_data  in  2*MULER_WIDTH  operand pair, [MULER_WIDTH-1:0]=a, upper half=b
- mac_num_valid  out  1  load pulse to MAC unit; also resets its core
- mac_num  out  NUM_WIDTH  counter load value
- mac_data  out  2*MULER_WIDTH  operand pair to MAC unit
- mac_data_ready  in  1  MAC unit result-ready pulse
- mac_result  in  OUTPUT_WIDTH  MAC unit result_r
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  OUTPUT_WIDTH  captured result
- res_last  out  1  qualifies the last tile's result of the job
- busy  out  1  state != IDLE
- err  out  1  sticky protocol/timeout error

Behaviour:
Reset:
- rst is asynchronous and active-high.
- On reset: state=IDLE; every output=0 except cmd_ready=1.
- All counters are cleared.
- Reset mid-job abandons the job; no result is emitted.

States: IDLE, LOAD, STREAM, DRAIN, CAPTURE, OUTPUT.

IDLE:
- cmd_ready=1.
- On cmd_valid: latch K and T, clear err.
- If K==0 or T==0: set err, stay IDLE; no MAC activity, no result.
- Otherwise go to LOAD with tiles_left=T.

LOAD:
- op_ready=0.
- Wait for op_valid=1. In that cycle drive mac_num_valid=1, mac_num=K-1, mac_data=0.
- Next state is STREAM with beat_cnt=K.

STREAM:
- op_ready=1, mac_data=op_data on each beat.
- beat_cnt decrements every cycle regardless of op_valid, because the MAC counter is cycle-based.
- If op_valid=0 in STREAM: drive mac_data=0, set err, do not consume.
- When beat_cnt reaches 1 and that cycle completes, go to DRAIN. Exactly K cycles are spent in STREAM.

DRAIN:
- mac_data=0, op_ready=0; watchdog counts.
- On mac_data_ready=1, go to CAPTURE.
- If the watchdog exceeds K+MULER_DELAY+4 cycles since the LOAD pulse: set err, return to IDLE, emit no result.

CAPTURE (one cycle):
- res_data<=mac_result, because the unit's result_r updates one cycle after data_ready.
- res_last<=(tiles_left==1).
- Go to OUTPUT.

OUTPUT:
- res_valid=1; res_data and res_last are held stable until res_ready.
- On res_ready: res_valid=0.
- If tiles_left==1: go to IDLE. Otherwise tiles_left-=1 and go to LOAD.

Rules:
- mac_num_valid is a single-cycle pulse, only in LOAD.
- mac_data_ready outside DRAIN is ignored.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Within a tile, operands are consumed only in STREAM, at most one per cycle.
- A zero operand injected on a bubble contributes 0 to the sum. The result is still delivered, with err set.
- err persists until the next accepted command or reset.
- Counters: beat_cnt is NUM_WIDTH bits; tiles_left is TILE_WIDTH bits. No wrap occurs for legal inputs.

Test Plan:
1. K=4, T=1, gapless operands (1,2),(3,4),(5,6),(7,8). Expect one mac_num_valid pulse with mac_num=3, then 4 STREAM beats, then res_valid with res_data=100 and res_last=1. err=0; busy drops after the handshake.
2. K=3, T=3, operands all (2,3), res_ready held low for 5 cycles on tile 2. Expect three results of 18 each; res_last=1 only on the third. res_data stays stable while stalled; no LOAD occurs during the stall.
3. K=4, T=1, op_valid=0 for the 3rd beat, pairs (1,1),(1,1),x,(1,1). Expect STREAM to last exactly 4 cycles, mac_data=0 on the bubble, res_data=3, err=1.
4. cmd_len=0 or cmd_tiles=0. Expect err=1, no mac_num_valid, no res_valid, cmd_ready stays 1.
5. K=2, model MAC never asserts mac_data_ready. Expect a watchdog timeout after 2+MULER_DELAY+4 cycles, err=1, return to IDLE, no result.
6. Assert rst asynchronously in the middle of STREAM of a K=8 job. Expect outputs to go to 0 immediately with cmd_ready=1; a new K=1 job with (5,5) then completes with res_data=25.
